// File: rtl/mem_ctrl_1000_if.sv
// Request/response bus between the interconnect and mem_ctrl_1000.
// Valid-only protocol with no ready: mem_req is taken when vld=1, and the controller
// drops it if the FIFO has no room. mem_rsp.vld is a one-cycle pulse that cannot be stalled.
interface mem_ctrl_1000_if;
  typedef struct packed {
    logic        vld;
    logic [1:0]  core_id;
    logic        opcode;   // 0 = READ, 1 = WRITE
    logic [31:0] addr;
    logic [31:0] data;
  } request_t;

  request_t mem_req;
  request_t mem_rsp;

  modport master (output mem_req, input mem_rsp);
  modport slave  (input mem_req, output mem_rsp);
endinterface

// File: rtl/mem_ctrl_1000.sv
// Memory-side request stage. An in-order request FIFO feeds a single-port word array
// that has a fixed access latency. Each serviced request produces one registered response.
module mem_ctrl_1000 #(
  parameter int MEM_DEPTH   = 1024,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACC_LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_ctrl_1000_if.slave bus,
  output logic           fifo_full,
  output logic           overflow_err,
  output logic           state_dbg
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;
  localparam logic [LW-1:0] CNT_LOAD   = LW'(ACC_LATENCY - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic          OP_WRITE   = 1'b1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [1:0]  q_core [FIFO_DEPTH];
  logic        q_op   [FIFO_DEPTH];
  logic [31:0] q_addr [FIFO_DEPTH];
  logic [31:0] q_data [FIFO_DEPTH];
  logic [31:0] mem    [MEM_DEPTH];

  logic [0:0]    state;
  logic [LW-1:0] cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;

  logic [1:0]    acc_core;
  logic          acc_op;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_data;
  logic [AW-1:0] acc_idx;

  logic done, pop, push, drop;

  assign state_dbg = state;
  assign acc_idx   = acc_addr[AW-1:0];

  // The completion edge both finishes the current access and may pop the next request.
  assign done = (state == S_BUSY) && (cnt == '0);
  assign pop  = (count != '0) && ((state == S_IDLE) || done);
  assign push = bus.mem_req.vld && ((count != COUNT_FULL) || pop);
  assign drop = bus.mem_req.vld && !push;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_core[wr_ptr] <= bus.mem_req.core_id;
      q_op[wr_ptr]   <= bus.mem_req.opcode;
      q_addr[wr_ptr] <= bus.mem_req.addr;
      q_data[wr_ptr] <= bus.mem_req.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_full    <= 1'b0;
      overflow_err <= 1'b0;
      acc_core     <= '0;
      acc_op       <= 1'b0;
      acc_addr     <= '0;
      acc_data     <= '0;
    end else begin
      count     <= count_next;
      fifo_full <= (count_next == COUNT_FULL);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop) overflow_err <= 1'b1;

      if (state == S_IDLE) begin
        if (pop) begin
          state <= S_BUSY;
          cnt   <= CNT_LOAD;
        end
      end else begin
        if (!done)
          cnt <= cnt - LW'(1);
        else if (pop)
          cnt <= CNT_LOAD;
        else
          state <= S_IDLE;
      end

      if (pop) begin
        acc_core <= q_core[rd_ptr];
        acc_op   <= q_op[rd_ptr];
        acc_addr <= q_addr[rd_ptr];
        acc_data <= q_data[rd_ptr];
      end
    end
  end

  // Array contents survive reset; only completed writes ever reach it.
  always_ff @(posedge clk) begin
    if (done && (acc_op == OP_WRITE))
      mem[acc_idx] <= acc_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_rsp <= '0;
    end else begin
      bus.mem_rsp.vld     <= done;
      bus.mem_rsp.core_id <= done ? acc_core : 2'b00;
      bus.mem_rsp.opcode  <= done ? acc_op : 1'b0;
      bus.mem_rsp.addr    <= done ? acc_addr : 32'h0;
      bus.mem_rsp.data    <= done ? ((acc_op == OP_WRITE) ? acc_data : mem[acc_idx]) : 32'h0;
    end
  end
endmodule

// File: tb/tb_mem_ctrl_1000.sv
// Bench for mem_ctrl_1000: two instances (access latency 2 and 4) share one request stream
// and are compared against a per-request timing and memory model.
`timescale 1ns/1ps
module tb_mem_ctrl_1000;
  localparam int FIFO_D = 4;
  localparam int RW     = 84;  // {stamp[15:0], vld, core[1:0], op, addr[31:0], data[31:0]}

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_ctrl_1000_if bus_a();
  mem_ctrl_1000_if bus_b();
  logic full_a, full_b, ovf_a, ovf_b, st_a, st_b;

  mem_ctrl_1000 #(.MEM_DEPTH(1024), .FIFO_DEPTH(FIFO_D), .ACC_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .fifo_full(full_a), .overflow_err(ovf_a), .state_dbg(st_a));
  mem_ctrl_1000 #(.MEM_DEPTH(1024), .FIFO_DEPTH(FIFO_D), .ACC_LATENCY(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .fifo_full(full_b), .overflow_err(ovf_b), .state_dbg(st_b));

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  int          lat [2] = '{2, 4};
  int          pend_s [2][$];   // pop edge of each accepted request still in the FIFO
  int          last_c [2];      // completion edge of the newest accepted request
  bit          ovf_m [2];
  bit          full_m [2];
  logic [31:0] mem_m [2][1024];
  logic [RW-1:0] exp_q [2][$];
  logic [RW-1:0] obs_q [2][$];

  always @(negedge clk) begin
    if (bus_a.mem_rsp != '0) obs_q[0].push_back({16'(edge_cnt - 1), bus_a.mem_rsp});
    if (bus_b.mem_rsp != '0) obs_q[1].push_back({16'(edge_cnt - 1), bus_b.mem_rsp});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Drives one edge. Requests are served in arrival order. A request starts one edge
  // after it arrives or at the completion edge of the request ahead of it, whichever
  // is later, and completes lat edges after it starts.
  task automatic drive_cycle(input logic vld, input logic [1:0] core, input logic op,
                             input logic [31:0] addr, input logic [31:0] data);
    int t, s, c, n;
    bit pop_now;
    logic [9:0]  idx;
    logic [31:0] rd;
    t = edge_cnt;
    bus_a.mem_req = {vld, core, op, addr, data};
    bus_b.mem_req = {vld, core, op, addr, data};
    for (int k = 0; k < 2; k++) begin
      while (pend_s[k].size() != 0 && pend_s[k][0] < t) void'(pend_s[k].pop_front());
      pop_now = (pend_s[k].size() != 0) && (pend_s[k][0] == t);
      if (vld) begin
        if (pend_s[k].size() < FIFO_D || pop_now) begin
          s = (t + 1 > last_c[k]) ? t + 1 : last_c[k];
          c = s + lat[k];
          last_c[k] = c;
          pend_s[k].push_back(s);
          idx = addr[9:0];
          if (op) mem_m[k][idx] = data;
          rd = mem_m[k][idx];
          exp_q[k].push_back({16'(c), 1'b1, core, op, addr, rd});
        end else begin
          ovf_m[k] = 1'b1;
        end
      end
      n = 0;
      for (int j = 0; j < pend_s[k].size(); j++) if (pend_s[k][j] > t) n++;
      full_m[k] = (n == FIFO_D);
    end
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 2'($urandom), 1'($urandom), $urandom, $urandom);
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b0;
    bus_a.mem_req = '0;
    bus_b.mem_req = '0;
    for (int k = 0; k < 2; k++) begin
      pend_s[k].delete();
      exp_q[k].delete();
      last_c[k] = 0;
      ovf_m[k] = 1'b0;
      full_m[k] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.mem_req = '0;
    bus_b.mem_req = '0;
    #1;
    checks++;
    if (bus_a.mem_rsp !== '0 || bus_b.mem_rsp !== '0) begin
      errors++;
      $display("FAIL reset_rsp got a=%h b=%h required 0", bus_a.mem_rsp, bus_b.mem_rsp);
    end
    hold_reset(3);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      checks++;
      if (bus_a.mem_rsp !== '0 || full_a !== 1'b0 || ovf_a !== 1'b0 ||
          bus_b.mem_rsp !== '0 || full_b !== 1'b0 || ovf_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got rsp_a=%h full_a=%b ovf_a=%b rsp_b=%h full_b=%b ovf_b=%b required all 0",
                 i, bus_a.mem_rsp, full_a, ovf_a, bus_b.mem_rsp, full_b, ovf_b);
      end
    end
  endtask

  task automatic test_write_read();
    int t0;
    logic [RW-1:0] got, exp_r, r0, r1;
    t0 = edge_cnt;
    drive_cycle(1'b1, 2'd2, 1'b1, 32'h10, 32'hDEAD);
    idle(9);
    drive_cycle(1'b1, 2'd1, 1'b0, 32'h10, 32'h0);
    idle(20);
    checks++;
    if (obs_q[0].size() < 2) begin
      errors++;
      $display("FAIL write_read_lat got %0d responses required 2", obs_q[0].size());
    end else begin
      r0 = obs_q[0][0];
      r1 = obs_q[0][1];
      if (r0[83:68] !== 16'(t0 + 3) || r0[66:65] !== 2'd2 || r0[31:0] !== 32'hDEAD ||
          r1[83:68] !== 16'(t0 + 13) || r1[66:65] !== 2'd1 || r1[31:0] !== 32'hDEAD) begin
        errors++;
        $display("FAIL write_read_lat got %h / %h required edges %0d,%0d core 2,1 data DEAD", r0, r1, t0 + 3, t0 + 13);
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        errors++;
        $display("FAIL write_read rsp_count dut%0d got %0d required %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (obs_q[k].size() != 0 && exp_q[k].size() != 0) begin
        got = obs_q[k].pop_front();
        exp_r = exp_q[k].pop_front();
        checks++;
        if (got !== exp_r) begin
          errors++;
          $display("FAIL write_read rsp dut%0d got %h required %h", k, got, exp_r);
        end
      end
      obs_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [RW-1:0] got, exp_r, r;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 2'($urandom), 1'b1, 32'(i), 32'hA0 + 32'(i));
    idle(30);
    for (int k = 0; k < 2; k++) begin
      obs_q[k].delete();
      exp_q[k].delete();
    end
    t0 = edge_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) drive_cycle(1'b1, 2'(i), 1'b0, 32'(i), $urandom);
      else idle(1);
      checks++;
      if (full_a !== 1'b0 || ovf_a !== 1'b0) begin
        errors++;
        $display("FAIL b2b_flags cycle %0d got full=%b ovf=%b required 0 0", i, full_a, ovf_a);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q[0].size() <= i) begin
        errors++;
        $display("FAIL b2b_order missing response %0d", i);
      end else begin
        r = obs_q[0][i];
        if (r[83:68] !== 16'(t0 + 3 + 2 * i) || r[31:0] !== 32'hA0 + 32'(i)) begin
          errors++;
          $display("FAIL b2b_order rsp %0d got edge %0d data %h required edge %0d data %h",
                   i, r[83:68], r[31:0], t0 + 3 + 2 * i, 32'hA0 + 32'(i));
        end
      end
    end
    idle(10);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        errors++;
        $display("FAIL b2b rsp_count dut%0d got %0d required %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (obs_q[k].size() != 0 && exp_q[k].size() != 0) begin
        got = obs_q[k].pop_front();
        exp_r = exp_q[k].pop_front();
        checks++;
        if (got !== exp_r) begin
          errors++;
          $display("FAIL b2b rsp dut%0d got %h required %h", k, got, exp_r);
        end
      end
      obs_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic test_push_pop_full();
    logic [RW-1:0] got, exp_r;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 2'($urandom), 1'b1, 32'h40 + 32'(i), $urandom);
      checks++;
      if (full_a !== full_m[0] || ovf_a !== ovf_m[0] || full_b !== full_m[1] || ovf_b !== ovf_m[1]) begin
        errors++;
        $display("FAIL push_pop_flags cycle %0d got full=%b/%b ovf=%b/%b required full=%b/%b ovf=%b/%b",
                 i, full_a, full_b, ovf_a, ovf_b, full_m[0], full_m[1], ovf_m[0], ovf_m[1]);
      end
    end
    checks++;
    if (full_b !== 1'b1 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_full got full=%b ovf=%b required full=1 ovf=0", full_b, ovf_b);
    end
    idle(40);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        errors++;
        $display("FAIL push_pop rsp_count dut%0d got %0d required %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (obs_q[k].size() != 0 && exp_q[k].size() != 0) begin
        got = obs_q[k].pop_front();
        exp_r = exp_q[k].pop_front();
        checks++;
        if (got !== exp_r) begin
          errors++;
          $display("FAIL push_pop rsp dut%0d got %h required %h", k, got, exp_r);
        end
      end
      obs_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic test_overflow();
    logic [RW-1:0] got, exp_r;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b1, 2'($urandom), 1'b1, 32'h80 + 32'(i), $urandom);
      checks++;
      if (full_a !== full_m[0] || ovf_a !== ovf_m[0] || full_b !== full_m[1] || ovf_b !== ovf_m[1]) begin
        errors++;
        $display("FAIL overflow_flags cycle %0d got full=%b/%b ovf=%b/%b required full=%b/%b ovf=%b/%b",
                 i, full_a, full_b, ovf_a, ovf_b, full_m[0], full_m[1], ovf_m[0], ovf_m[1]);
      end
    end
    idle(40);
    checks++;
    if (ovf_b !== 1'b1 || ovf_a !== 1'b0 || obs_q[1].size() != 6) begin
      errors++;
      $display("FAIL overflow_sticky got ovf_b=%b ovf_a=%b rsp_b=%0d required 1 0 6", ovf_b, ovf_a, obs_q[1].size());
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        errors++;
        $display("FAIL overflow rsp_count dut%0d got %0d required %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (obs_q[k].size() != 0 && exp_q[k].size() != 0) begin
        got = obs_q[k].pop_front();
        exp_r = exp_q[k].pop_front();
        checks++;
        if (got !== exp_r) begin
          errors++;
          $display("FAIL overflow rsp dut%0d got %h required %h", k, got, exp_r);
        end
      end
      obs_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [RW-1:0] got, exp_r, r;
    hold_reset(2);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'($urandom), 1'b0, 32'(i), $urandom);
    checks++;
    if (st_a !== 1'b1 || st_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy got state a=%b b=%b required 1 1", st_a, st_b);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus_a.mem_rsp !== '0 || bus_b.mem_rsp !== '0 || full_a !== 1'b0 || full_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_now got rsp a=%h b=%h full=%b/%b required 0", bus_a.mem_rsp, bus_b.mem_rsp, full_a, full_b);
    end
    hold_reset(2);
    idle(12);
    checks++;
    if (obs_q[0].size() != 0 || obs_q[1].size() != 0) begin
      errors++;
      $display("FAIL reset_mid_stale got %0d/%0d responses required 0", obs_q[0].size(), obs_q[1].size());
    end
    t0 = edge_cnt;
    drive_cycle(1'b1, 2'd3, 1'b0, 32'h2, 32'h0);
    idle(10);
    checks++;
    if (obs_q[0].size() == 0) begin
      errors++;
      $display("FAIL reset_mid_read got no response required edge %0d", t0 + 3);
    end else begin
      r = obs_q[0][0];
      if (r[83:68] !== 16'(t0 + 3) || r[31:0] !== 32'hA2 || r[66:65] !== 2'd3) begin
        errors++;
        $display("FAIL reset_mid_read got %h required edge %0d core 3 data A2", r, t0 + 3);
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        errors++;
        $display("FAIL reset_mid rsp_count dut%0d got %0d required %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (obs_q[k].size() != 0 && exp_q[k].size() != 0) begin
        got = obs_q[k].pop_front();
        exp_r = exp_q[k].pop_front();
        checks++;
        if (got !== exp_r) begin
          errors++;
          $display("FAIL reset_mid rsp dut%0d got %h required %h", k, got, exp_r);
        end
      end
      obs_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] got, exp_r;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 2'($urandom), 1'b1, 32'(i), $urandom);
      idle(4);
    end
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 7)) << 10) | 32'($urandom_range(0, 15));
      drive_cycle(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom), a, $urandom);
      checks++;
      if (full_a !== full_m[0] || ovf_a !== ovf_m[0] || full_b !== full_m[1] || ovf_b !== ovf_m[1]) begin
        errors++;
        $display("FAIL random_flags cycle %0d got full=%b/%b ovf=%b/%b required full=%b/%b ovf=%b/%b",
                 i, full_a, full_b, ovf_a, ovf_b, full_m[0], full_m[1], ovf_m[0], ovf_m[1]);
      end
    end
    idle(40);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        errors++;
        $display("FAIL random rsp_count dut%0d got %0d required %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (obs_q[k].size() != 0 && exp_q[k].size() != 0) begin
        got = obs_q[k].pop_front();
        exp_r = exp_q[k].pop_front();
        checks++;
        if (got !== exp_r) begin
          errors++;
          $display("FAIL random rsp dut%0d got %h required %h", k, got, exp_r);
        end
      end
      obs_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_push_pop_full();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_1000.md
Name: mem_ctrl_1000

Overview:
- Memory-side stage directly downstream of the core-to-memory interconnect.
- Consumes the arbitrated request_t stream (mem_req) and buffers it in an in-order request FIFO.
- Services each request against a single-port word-addressed memory array with a programmable fixed access latency.
- Returns one request_t response per request on mem_rsp, echoing core_id so the interconnect can route it back to the issuing core.

Parameters:
- MEM_DEPTH, 1024, number of data words in the array; address is taken modulo MEM_DEPTH (low $clog2(MEM_DEPTH) bits of addr).
- FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2.
- ACC_LATENCY, 2, clock edges a request spends in the access stage; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- mem_req  input  request_t  request from the interconnect. Fields used: vld, core_id, opcode (READ/WRITE), addr, data. The entry is sampled only when vld=1.
- mem_rsp  output  request_t  registered response. Fields: vld (one-cycle pulse), core_id, opcode and addr echoed, data (read data, or write data echoed).
- fifo_full  output  1  request FIFO holds FIFO_DEPTH entries; registered.
- overflow_err  output  1  sticky flag: a valid request arrived while the FIFO was full and no pop occurred that edge.

Behaviour:
- Reset (async, reset=0):
  - mem_rsp=0, fifo_full=0, overflow_err=0.
  - FIFO pointers and count=0; FSM=IDLE; latency counter=0.
  - Array contents are not reset. Reset mid-access discards the FIFO and the in-flight request, and no response is produced for them.
- FIFO push: on an edge with mem_req.vld=1, the whole mem_req is written if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop happens on the same edge.
  - Otherwise the request is dropped and overflow_err is set to 1. It is cleared only by reset.
- FIFO pop: performed only by the FSM, as described below. Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_full reflects the post-edge count.
- FSM states: IDLE, BUSY.
  - IDLE: if FIFO is non-empty at the edge, pop the head into the access register, load cnt=ACC_LATENCY-1, and go to BUSY. A request pushed on edge N is visible to pop at edge N+1 (no bypass).
  - BUSY, cnt!=0: decrement cnt.
  - BUSY, cnt==0 (completion edge):
    - Perform the access. WRITE stores data at addr. READ captures array[addr], which reflects all earlier writes.
    - Register mem_rsp with vld=1 and the echoed fields.
    - If the FIFO is non-empty, pop the next request, reload cnt, and stay in BUSY. Otherwise go to IDLE.
- mem_rsp.vld is high for exactly one cycle per serviced request. On all other cycles mem_rsp=0.
- Latency: with the FIFO empty and the FSM in IDLE, a request sampled at edge N gives mem_rsp.vld=1 after edge N+1+ACC_LATENCY.
- Throughput: one response per ACC_LATENCY cycles under back-to-back load.
- Ordering: strictly in FIFO arrival order. Read-after-write to the same address returns the new data.
- Only one array access per cycle; no read/write port conflict exists.
- core_id is not interpreted; values 0-3 are passed through unchanged.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, run 10 cycles with no requests -> mem_rsp=0, fifo_full=0, overflow_err=0 throughout.
- Single write then read (ACC_LATENCY=2):
  - Stimulus: WRITE core_id=2 addr=0x10 data=0xDEAD at edge 0; READ core_id=1 addr=0x10 at edge 10.
  - Required: rsp vld after edge 3 with core_id=2, data=0xDEAD; rsp vld after edge 13 with core_id=1, data=0xDEAD.
- Back-to-back reads (ACC_LATENCY=2): 4 READs to addr 0..3 (preloaded 0xA0..0xA3) on edges 0-3 -> responses after edges 3, 5, 7, 9 with data 0xA0..0xA3 in order; fifo_full never 1; overflow_err=0.
- Overflow (FIFO_DEPTH=4, ACC_LATENCY=4): valid requests on 7 consecutive edges -> fifo_full=1 once 4 entries are held without a pop, at least one request dropped, overflow_err=1 and stays 1; only the accepted requests respond, in order.
- Push and pop on the same edge at full: arrange count==4 with a pop due on edge K and a request arriving at edge K -> request accepted, count stays 4, overflow_err=0.
- Reset mid-access: assert reset while BUSY with 2 entries queued -> mem_rsp=0 immediately; after release no stale responses appear; a new READ completes with the normal latency.
